// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence-detect link: FSM encodings,
// the default framing pattern and a constant-width helper.
package seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  localparam logic [2:0] SEQ_100 = 3'b100;

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Request/response bundle between a pattern-transmit client and seq_pattern_tx.
interface seq_pattern_tx_if #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pat_in;
  logic [CNT_W-1:0] rep_in;
  logic             xout;
  logic             xvalid;
  logic             busy;
  logic             done;

  modport master (
    output start, pat_in, rep_in,
    input  xout, xvalid, busy, done
  );

  modport slave (
    input  start, pat_in, rep_in,
    output xout, xvalid, busy, done
  );
endinterface

// File: rtl/seq_piso.sv
// MSB-first parallel-in/serial-out register with a held copy of the pattern
// so repeats can be reloaded without looking at the live input again.
module seq_piso #(
  parameter int PAT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic             reload,
  input  logic [PAT_W-1:0] pat_in,
  output logic             nxt_bit
);

  logic [PAT_W-1:0] sreg_q, sreg_d;
  logic [PAT_W-1:0] copy_q, copy_d;

  // sreg holds only the bits still to be sent; the bit leaving on a load or
  // reload is taken straight from the source so it can be registered at once.
  always_comb begin
    sreg_d  = sreg_q;
    copy_d  = copy_q;
    nxt_bit = sreg_q[PAT_W-1];
    if (load) begin
      copy_d  = pat_in;
      sreg_d  = pat_in << 1;
      nxt_bit = pat_in[PAT_W-1];
    end else if (reload) begin
      sreg_d  = copy_q << 1;
      nxt_bit = copy_q[PAT_W-1];
    end else if (shift) begin
      sreg_d  = sreg_q << 1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg_q <= '0;
      copy_q <= '0;
    end else begin
      sreg_q <= sreg_d;
      copy_q <= copy_d;
    end
  end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB first, repeated
// rep_in+1 times with optional idle gaps, then pulses done.
module seq_pattern_tx #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 4,
  parameter int GAP   = 0
) (
  input  logic            clk,
  input  logic            reset,
  seq_pattern_tx_if.slave bus
);
  import seq_pkg::*;

  localparam int BIT_W = clog2(PAT_W);
  localparam int GAP_W = clog2(GAP + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  state_e           state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             xout_q, xout_d;
  logic             xvalid_q, xvalid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load, shift, reload, nxt_bit;

  seq_piso #(.PAT_W(PAT_W)) u_piso (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .shift   (shift),
    .reload  (reload),
    .pat_in  (bus.pat_in),
    .nxt_bit (nxt_bit)
  );

  // Next-state logic computes what the outputs show in the following cycle.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;
    gap_cnt_d = gap_cnt_q;
    xout_d    = 1'b0;
    xvalid_d  = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    reload    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          load      = 1'b1;
          state_d   = S_SHIFT;
          bit_cnt_d = BIT_LAST;
          rep_cnt_d = bus.rep_in;
          xout_d    = nxt_bit;
          xvalid_d  = 1'b1;
          busy_d    = 1'b1;
        end
      end
      S_SHIFT: begin
        busy_d = 1'b1;
        if (bit_cnt_q != '0) begin
          shift     = 1'b1;
          bit_cnt_d = bit_cnt_q - BIT_W'(1);
          xout_d    = nxt_bit;
          xvalid_d  = 1'b1;
        end else if (rep_cnt_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q - CNT_W'(1);
          if (GAP == 0) begin
            reload    = 1'b1;
            bit_cnt_d = BIT_LAST;
            xout_d    = nxt_bit;
            xvalid_d  = 1'b1;
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LAST;
          end
        end
      end
      S_GAP: begin
        busy_d = 1'b1;
        if (gap_cnt_q == '0) begin
          state_d   = S_SHIFT;
          reload    = 1'b1;
          bit_cnt_d = BIT_LAST;
          xout_d    = nxt_bit;
          xvalid_d  = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
      xout_q    <= 1'b0;
      xvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      xout_q    <= xout_d;
      xvalid_q  <= xvalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.xout   = xout_q;
  assign bus.xvalid = xvalid_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: one instance back-to-back (GAP=0),
// one with two-cycle gaps (GAP=2).
module tb_seq_pattern_tx;
  import seq_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  seq_pattern_tx_if #(.PAT_W(3), .CNT_W(4)) if0 ();
  seq_pattern_tx_if #(.PAT_W(3), .CNT_W(4)) if1 ();

  seq_pattern_tx #(.PAT_W(3), .CNT_W(4), .GAP(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  seq_pattern_tx #(.PAT_W(3), .CNT_W(4), .GAP(2)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  int  checks = 0;
  int  errors = 0;
  bit  mon_en0 = 1'b1;
  byte q0[$];
  byte q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected-stream characters: '1'/'0' pattern bit, 'g' gap cycle, 'D' done cycle.
  function automatic logic [2:0] exp_of(input byte c);
    case (c)
      "1":     return 3'b110;
      "0":     return 3'b010;
      "g":     return 3'b000;
      "D":     return 3'b001;
      default: return 3'b111;
    endcase
  endfunction

  always @(negedge clk) begin
    byte e;
    if (mon_en0) begin
      if (if0.busy) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut0_extra_busy actual=1 required=0");
        end else begin
          e = q0.pop_front();
          chk("dut0_stream", {29'd0, if0.xout, if0.xvalid, if0.done}, {29'd0, exp_of(e)});
        end
      end else begin
        chk("dut0_idle", {29'd0, if0.xout, if0.xvalid, if0.done}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    byte e;
    if (if1.busy) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_extra_busy actual=1 required=0");
      end else begin
        e = q1.pop_front();
        chk("dut1_stream", {29'd0, if1.xout, if1.xvalid, if1.done}, {29'd0, exp_of(e)});
      end
    end else begin
      chk("dut1_idle", {29'd0, if1.xout, if1.xvalid, if1.done}, 32'd0);
    end
  end

  function automatic logic busy_of(input int which);
    return (which == 0) ? if0.busy : if1.busy;
  endfunction

  function automatic logic valid_of(input int which);
    return (which == 0) ? if0.xvalid : if1.xvalid;
  endfunction

  task automatic drive(input int which, input logic s, input logic [2:0] p, input logic [3:0] r);
    if (which == 0) begin
      if0.start = s; if0.pat_in = p; if0.rep_in = r;
    end else begin
      if1.start = s; if1.pat_in = p; if1.rep_in = r;
    end
  endtask

  task automatic push(input int which, input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (which == 0) q0.push_back(s[i]);
      else            q1.push_back(s[i]);
    end
  endtask

  task automatic wait_idle(input int which);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (!busy_of(which)) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL wait_idle_timeout dut=%0d busy=1 required=0", which);
    end
  endtask

  // Starts a transmission; with now=1 the start is raised in the current
  // (already reached) idle cycle so it is accepted at the very next edge.
  task automatic send(input int which, input logic [2:0] pat, input logic [3:0] rep,
                      input string exp, input bit now);
    push(which, exp);
    if (!now) @(negedge clk);
    drive(which, 1'b1, pat, rep);
    @(posedge clk); #1;
    drive(which, 1'b0, ~pat, rep + 4'd3);
    chk("start_latency", {30'd0, busy_of(which), valid_of(which)}, 32'd3);
    wait_idle(which);
  endtask

  initial begin
    string s;
    drive(0, 1'b0, 3'b000, 4'd0);
    drive(1, 1'b0, 3'b000, 4'd0);

    // Reset held with start toggling
    repeat (3) begin
      @(negedge clk);
      if0.start = ~if0.start; if0.pat_in = SEQ_100;
      if1.start = ~if1.start; if1.pat_in = 3'b101;
      #1;
      chk("reset_outs0", {28'd0, if0.xout, if0.xvalid, if0.busy, if0.done}, 32'd0);
      chk("reset_outs1", {28'd0, if1.xout, if1.xvalid, if1.busy, if1.done}, 32'd0);
    end
    drive(0, 1'b0, SEQ_100, 4'd0);
    drive(1, 1'b0, 3'b101, 4'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_reset_idle", {30'd0, if0.busy, if1.busy}, 32'd0);
    end

    send(0, SEQ_100, 4'd0, "100D", 1'b0);
    send(0, 3'b100, 4'd1, "100100D", 1'b1);
    send(1, 3'b101, 4'd2, "101gg101gg101D", 1'b0);
    send(1, 3'b110, 4'd1, "110gg110D", 1'b0);
    send(1, 3'b011, 4'd0, "011D", 1'b0);
    send(0, 3'b011, 4'd2, "011011011D", 1'b0);

    s = "";
    repeat (16) s = {s, "100"};
    s = {s, "D"};
    send(0, 3'b100, 4'd15, s, 1'b0);

    // start held through the whole transmission and its done cycle, inputs changed
    push(0, "100D");
    @(negedge clk);
    drive(0, 1'b1, 3'b100, 4'd0);
    @(posedge clk); #1;
    drive(0, 1'b1, 3'b011, 4'd5);
    repeat (4) @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 3'b011, 4'd5);
    repeat (6) @(negedge clk);
    chk("ignored_start_idle", {31'd0, if0.busy}, 32'd0);

    // Abort during the second bit
    mon_en0 = 1'b0;
    @(negedge clk);
    drive(0, 1'b1, 3'b100, 4'd3);
    @(posedge clk); #1;
    drive(0, 1'b0, 3'b100, 4'd3);
    @(posedge clk); #1;
    chk("abort_second_bit", {30'd0, if0.xout, if0.xvalid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_async0", {28'd0, if0.xout, if0.xvalid, if0.busy, if0.done}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_done", {30'd0, if0.busy, if0.done}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("abort_stays_idle", {30'd0, if0.busy, if0.done}, 32'd0);
    end
    mon_en0 = 1'b1;
    send(0, 3'b110, 4'd0, "110D", 1'b0);

    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
